// File: rtl/ex_mem_skid_reg_if.sv
// EX->MEM handshake bundle: EX-side inputs, MEM-side outputs, flush and stall counter.
// The slave modport is the pipeline register's view; master is the surrounding pipeline.
interface ex_mem_skid_reg_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH     = 8
);
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH-1:0]     ALUResultE;
    logic [DATA_WIDTH-1:0]     WriteDataE;
    logic [REG_ADDR_WIDTH-1:0] RdE;
    logic [DATA_WIDTH-1:0]     PCTargetE;
    logic [DATA_WIDTH-1:0]     PCPlus4E;
    logic [CTRL_WIDTH-1:0]     CtrlE;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     ALUResultM;
    logic [DATA_WIDTH-1:0]     WriteDataM;
    logic [REG_ADDR_WIDTH-1:0] RdM;
    logic [DATA_WIDTH-1:0]     PCTargetM;
    logic [DATA_WIDTH-1:0]     PCPlus4M;
    logic [CTRL_WIDTH-1:0]     CtrlM;
    logic [31:0]               stall_count;

    modport master (
        output flush, in_valid, ALUResultE, WriteDataE, RdE, PCTargetE, PCPlus4E, CtrlE,
        output out_ready,
        input  in_ready, out_valid, ALUResultM, WriteDataM, RdM, PCTargetM, PCPlus4M,
        input  CtrlM, stall_count
    );

    modport slave (
        input  flush, in_valid, ALUResultE, WriteDataE, RdE, PCTargetE, PCPlus4E, CtrlE,
        input  out_ready,
        output in_ready, out_valid, ALUResultM, WriteDataM, RdM, PCTargetM, PCPlus4M,
        output CtrlM, stall_count
    );
endinterface

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register with 2-entry skid buffer; in_ready is registered so MEM stalls
// never form a combinational path into EX. Optional stall counter: define EXMEM_STALL_CNT_EN.
module ex_mem_skid_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH     = 8
) (
    input logic              clk,
    input logic              rst,
    ex_mem_skid_reg_if.slave bus
);
    localparam int PAY_W = 4*DATA_WIDTH + REG_ADDR_WIDTH + CTRL_WIDTH;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             in_ready_reg;
    logic [PAY_W-1:0] main_reg;
    logic [PAY_W-1:0] skid_reg;
    logic [PAY_W-1:0] in_payload;
    logic             load_main_in, load_main_skid, load_skid;
    logic             accept, take, out_valid;
    logic [CTRL_WIDTH-1:0] main_ctrl;

    assign in_payload = {bus.ALUResultE, bus.WriteDataE, bus.RdE,
                         bus.PCTargetE, bus.PCPlus4E, bus.CtrlE};

    assign out_valid = (state_reg != ST_EMPTY);
    assign accept    = bus.in_valid & in_ready_reg;
    assign take      = out_valid & bus.out_ready;

    always_comb begin
        state_next     = state_reg;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    state_next   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && take) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    load_skid  = 1'b1;
                    state_next = ST_TWO;
                end else if (take) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (take) begin
                    load_main_skid = 1'b1;
                    state_next     = ST_ONE;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
        // Flush wins: drop held entries and the incoming one; a concurrent take still completes.
        if (bus.flush) begin
            state_next     = ST_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_EMPTY;
            in_ready_reg <= 1'b1;
            main_reg     <= '0;
            skid_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != ST_TWO);
            if (load_main_in) begin
                main_reg <= in_payload;
            end else if (load_main_skid) begin
                main_reg <= skid_reg;
            end
            if (load_skid) begin
                skid_reg <= in_payload;
            end
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid;
    assign {bus.ALUResultM, bus.WriteDataM, bus.RdM,
            bus.PCTargetM, bus.PCPlus4M, main_ctrl} = main_reg;

    // Bubbles must never assert RegWrite/MemWrite downstream.
    for (genvar gi = 0; gi < CTRL_WIDTH; gi++) begin : g_ctrl_gate
        assign bus.CtrlM[gi] = main_ctrl[gi] & out_valid;
    end

`ifdef EXMEM_STALL_CNT_EN
    logic [31:0] stall_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_reg <= 32'd0;
        end else if (out_valid && !bus.out_ready && (stall_count_reg != 32'hFFFF_FFFF)) begin
            stall_count_reg <= stall_count_reg + 32'd1;
        end
    end

    assign bus.stall_count = stall_count_reg;
`else
    assign bus.stall_count = 32'd0;
`endif
endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed bench for ex_mem_skid_reg: reset, streaming, skid, flush, bubble gating, stall counter.
module tb_ex_mem_skid_reg;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 8;
`ifdef EXMEM_STALL_CNT_EN
    localparam bit STALL_ON = 1'b1;
`else
    localparam bit STALL_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    ex_mem_skid_reg_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .CTRL_WIDTH(CW)) bus_if ();

    ex_mem_skid_reg #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .CTRL_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                         input logic [7:0] ctrl);
        bus_if.in_valid   = v;
        bus_if.ALUResultE = alu;
        bus_if.WriteDataE = alu + 32'h100;
        bus_if.RdE        = rd;
        bus_if.PCTargetE  = alu + 32'h200;
        bus_if.PCPlus4E   = alu + 32'h4;
        bus_if.CtrlE      = ctrl;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst               = 1'b1;
        bus_if.flush      = 1'b0;
        bus_if.out_ready  = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 8'h00);
        #2;
        check("reset_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("reset_in_ready",  {31'd0, bus_if.in_ready}, 32'd1);
        check("reset_ctrl",      {24'd0, bus_if.CtrlM}, 32'd0);
        check("reset_alu",       bus_if.ALUResultM, 32'd0);
        check("reset_stall",     bus_if.stall_count, 32'd0);
        cyc();
        rst = 1'b0;

        // Stall counter: one entry held for 7 cycles with MEM stalled
        drive(1'b1, 32'h55, 5'd3, 8'h05);
        cyc();
        drive(1'b0, 32'h0, 5'd0, 8'h00);
        check("stall_load_valid", {31'd0, bus_if.out_valid}, 32'd1);
        for (int i = 0; i < 7; i++) cyc();
        check("stall_7", bus_if.stall_count, STALL_ON ? 32'd7 : 32'd0);
        bus_if.flush     = 1'b1;
        bus_if.out_ready = 1'b1;
        cyc();
        bus_if.flush     = 1'b0;
        bus_if.out_ready = 1'b0;
        cyc();
        check("stall_after_flush", bus_if.stall_count, STALL_ON ? 32'd7 : 32'd0);
        check("stall_flush_valid", {31'd0, bus_if.out_valid}, 32'd0);

        // Streaming at full throughput
        bus_if.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, i, 5'(i + 4), 8'(8'h10 + i));
            cyc();
            check($sformatf("stream_alu_%0d", i), bus_if.ALUResultM, i);
            check($sformatf("stream_rd_%0d", i),  {27'd0, bus_if.RdM}, i + 4);
            check($sformatf("stream_ctrl_%0d", i), {24'd0, bus_if.CtrlM}, 32'h10 + i);
            check($sformatf("stream_rdy_%0d", i), {31'd0, bus_if.in_ready}, 32'd1);
        end
        check("stream_wdata", bus_if.WriteDataM, 32'h104);
        check("stream_pct",   bus_if.PCTargetM, 32'h204);
        check("stream_pc4",   bus_if.PCPlus4M, 32'h8);
        drive(1'b0, 32'h0, 5'd0, 8'h00);
        cyc();
        check("stream_drain_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("stream_drain_hold",  bus_if.ALUResultM, 32'd4);
        check("stream_drain_ctrl",  {24'd0, bus_if.CtrlM}, 32'd0);

        // Skid: A, B back-to-back into a stalled MEM stage
        bus_if.out_ready = 1'b0;
        drive(1'b1, 32'hA, 5'd10, 8'hA1);
        cyc();
        check("skid_a_alu", bus_if.ALUResultM, 32'hA);
        check("skid_a_rdy", {31'd0, bus_if.in_ready}, 32'd1);
        drive(1'b1, 32'hB, 5'd11, 8'hB2);
        cyc();
        check("skid_two_rdy",  {31'd0, bus_if.in_ready}, 32'd0);
        check("skid_two_ctrl", {24'd0, bus_if.CtrlM}, 32'hA1);
        check("skid_two_alu",  bus_if.ALUResultM, 32'hA);
        drive(1'b1, 32'hC, 5'd12, 8'hC3);
        cyc();
        check("skid_hold_alu", bus_if.ALUResultM, 32'hA);
        check("skid_hold_rdy", {31'd0, bus_if.in_ready}, 32'd0);
        drive(1'b0, 32'h0, 5'd0, 8'h00);
        bus_if.out_ready = 1'b1;
        cyc();
        check("skid_b_alu",  bus_if.ALUResultM, 32'hB);
        check("skid_b_rd",   {27'd0, bus_if.RdM}, 32'd11);
        check("skid_b_ctrl", {24'd0, bus_if.CtrlM}, 32'hB2);
        check("skid_b_rdy",  {31'd0, bus_if.in_ready}, 32'd1);
        cyc();
        check("skid_empty_valid", {31'd0, bus_if.out_valid}, 32'd0);

        // Flush from TWO with an incoming entry in the same cycle
        bus_if.out_ready = 1'b0;
        drive(1'b1, 32'h1A, 5'd1, 8'h33);
        cyc();
        drive(1'b1, 32'h1B, 5'd2, 8'h44);
        cyc();
        check("flush_pre_rdy", {31'd0, bus_if.in_ready}, 32'd0);
        drive(1'b1, 32'hC, 5'd12, 8'h77);
        bus_if.flush = 1'b1;
        cyc();
        bus_if.flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 8'h00);
        check("flush_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("flush_ctrl",  {24'd0, bus_if.CtrlM}, 32'd0);
        check("flush_rdy",   {31'd0, bus_if.in_ready}, 32'd1);
        bus_if.out_ready = 1'b1;
        cyc();
        check("flush_no_c_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("flush_no_c_alu",   bus_if.ALUResultM, 32'h1A);

        // Bubble gating
        bus_if.out_ready = 1'b0;
        drive(1'b0, 32'h99, 5'd9, 8'hFF);
        cyc();
        check("bubble_ctrl",  {24'd0, bus_if.CtrlM}, 32'd0);
        check("bubble_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("stall_total",  bus_if.stall_count, STALL_ON ? 32'd11 : 32'd0);

        // Async reset mid-cycle while in TWO
        drive(1'b1, 32'h21, 5'd4, 8'h21);
        cyc();
        drive(1'b1, 32'h22, 5'd5, 8'h22);
        cyc();
        drive(1'b0, 32'h0, 5'd0, 8'h00);
        check("rst_pre_rdy", {31'd0, bus_if.in_ready}, 32'd0);
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("rst_mid_rdy",   {31'd0, bus_if.in_ready}, 32'd1);
        check("rst_mid_ctrl",  {24'd0, bus_if.CtrlM}, 32'd0);
        check("rst_mid_alu",   bus_if.ALUResultM, 32'd0);
        check("rst_mid_stall", bus_if.stall_count, 32'd0);
        cyc();
        rst = 1'b0;
        bus_if.out_ready = 1'b1;
        drive(1'b1, 32'h10, 5'd16, 8'h01);
        cyc();
        drive(1'b0, 32'h0, 5'd0, 8'h00);
        check("rst_first_alu",   bus_if.ALUResultM, 32'h10);
        check("rst_first_valid", {31'd0, bus_if.out_valid}, 32'd1);
        check("rst_first_ctrl",  {24'd0, bus_if.CtrlM}, 32'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
